prog_loader_sap: RTL and testbench
==================================

# prog_loader_sap

Program loader that sits directly upstream of the SAP RAM. It accepts a length-prefixed byte stream from a host over a valid/ready handshake and writes the bytes into RAM addresses 0..N-1. It holds the SAP core in clear until the image is complete, then releases it. It replaces hand-programming of RAM contents before the first run.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; capacity is 2**ADDR_W bytes.
- DATA_W, 8, RAM word and stream byte width.
- HOLD_CYCLES, 2, cycles `sap_clr` stays high after the last byte is accepted (legal range 1..15).

Ports:
- clk  in  1  system clock; everything is rising-edge.
- clr  in  1  reset, asynchronous and active-low.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  loader can accept a byte.
- load_req  in  1  single-cycle restart request.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- sap_clr  out  1  active-high clear to the SAP core.
- busy  out  1  high in LOAD, CHECK and HOLD.
- done  out  1  high in RUN.
- err  out  1  high in ERR.

## Operation
- A byte is transferred on a rising edge where `in_valid` and `in_ready` are both high. `in_data` is ignored at all other times.
- States:
  - IDLE, LEN, LOAD, CHECK, HOLD, RUN and ERR are the state names.
  - IDLE: `in_ready`=1. The first byte transferred is the length L.
    - L in 1..2**ADDR_W goes to LOAD.
    - Any other L, including 0, goes to ERR.
  - LOAD: `in_ready`=1. Data byte k (k=0..L-1) produces one write to address k. After byte L-1 the next state is CHECK if the checksum option is compiled in, otherwise HOLD.
  - CHECK: `in_ready`=1. One checksum byte is transferred. A pass goes to HOLD; a mismatch goes to ERR.
  - HOLD: `in_ready`=0. Waits HOLD_CYCLES cycles, then goes to RUN.
  - RUN: `in_ready`=0 and `sap_clr`=0. `load_req` goes to IDLE.
  - ERR: `in_ready`=0 and `sap_clr`=1. `load_req` goes to IDLE.
- `load_req` has no effect in IDLE, LOAD, CHECK or HOLD.
- `sap_clr`=1 in every state except RUN.
- RAM contents are never cleared by the loader. A partial image stays in RAM after an error or a reset.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=1.
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `sap_clr`=1.
  - `busy`=0, `done`=0, `err`=0.
- All outputs are registered or are direct decodes of the state register.
- Write latency is 1:
  - A data byte accepted at edge t drives `ram_we`=1 with its `ram_addr`/`ram_wdata` for exactly one cycle, t..t+1.
  - The write of the last byte overlaps the first HOLD or CHECK cycle.
- Backpressure: cycles with `in_valid`=0 produce no write. Addresses stay contiguous regardless of gaps.
- Entering HOLD at edge t gives RUN at edge t+HOLD_CYCLES. `sap_clr` falls at that same edge.
- `load_req` sampled high in RUN or ERR at edge t gives IDLE at edge t, with `sap_clr`=1 and `in_ready`=1 from that edge.
- Asserting `clr` mid-load forces the reset values immediately. Any pending write strobe is dropped.
- Length L=2**ADDR_W: the address counter must not wrap before the last write.

## Configuration
- PROG_LOADER_CHKSUM_EN defined:
  - The CHECK state exists.
  - The loader keeps an 8-bit modulo-256 sum of the L data bytes.
  - The trailing byte passes if (sum + byte) mod 256 == 0.
- Undefined:
  - No CHECK state and no accumulator.
  - LOAD goes straight to HOLD.
  - The stream is exactly L+1 bytes.

## Structure
- Package `prog_loader_sap_pkg`:
  - State enumeration.
  - Default ADDR_W/DATA_W constants.
  - Length-byte legality limit.
- One sub-module, `prog_loader_chksum`: the accumulator, with clear/add/compare. It is instantiated only under PROG_LOADER_CHKSUM_EN.

## Test plan
- Reset: drive `clr`=0 mid-cycle -> the reset values listed under Timing appear without waiting for a clock edge.
- Demo image, macro off: stream 0C, 09 E0 1A 2B E0 F0 00 00 00 36 0F 0E -> 12 single-cycle writes to addresses 0..11 with matching data; `done`=1 and `sap_clr`=0 exactly 2 cycles after the 13th byte is accepted.
- Illegal length: stream 00 -> `err`=1, `sap_clr`=1, `in_ready`=0, no writes; `load_req` pulse -> IDLE, `in_ready`=1. Repeat with length 11h -> same result.
- Backpressure: length 03, data AA BB CC with 2 idle cycles between bytes -> exactly 3 writes to addresses 0,1,2, none during gaps.
- Checksum, macro on: 02 01 02 FD -> `done`=1; 02 01 02 FE -> `err`=1, `sap_clr` stays 1.
- Reset mid-load after 3 of 5 data bytes -> IDLE, `ram_we`=0; a fresh load of 01 55 writes 55 to address 0.

Source files
------------

// File: rtl/prog_loader_sap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_sap_pkg
// Brief    : States, default widths and length-byte limits for prog_loader_sap.
// Revision : 1.0
// ============================================================================
package prog_loader_sap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_HOLD  = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic [31:0] LEN_MIN = 32'd1;

  // Legal image lengths are 1..2**addr_w inclusive.
  function automatic logic len_legal(input logic [31:0] len, input int addr_w);
    return (len >= LEN_MIN) && (len <= (32'd1 << addr_w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_chksum.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_chksum
// Brief    : 8-bit modulo-256 byte accumulator; pass when sum + trailer == 0.
// Revision : 1.0
// ============================================================================
module prog_loader_chksum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic              pass
);

  logic [7:0] sum;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (add) begin
      sum <= sum + 8'(data);
    end
  end

  assign pass = ((sum + 8'(data)) == 8'h00);

endmodule
`default_nettype wire

// File: rtl/prog_loader_sap.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_sap
// Brief    : Length-prefixed stream loader for SAP RAM; holds the core in clear
//            until the image is written. Macro PROG_LOADER_CHKSUM_EN adds a
//            trailing checksum byte and the CHECK state.
// Revision : 1.0
// ============================================================================
module prog_loader_sap
  import prog_loader_sap_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              sap_clr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so a full 2**ADDR_W image is counted without wrapping.
  localparam int LEN_W = ADDR_W + 1;

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [3:0]       hold_cnt;
  logic             accept;
  logic             len_ok;
  logic             last_byte;

  assign accept    = in_valid & in_ready;
  assign len_ok    = len_legal(32'(in_data), ADDR_W);
  assign last_byte = ((cnt + LEN_W'(1)) == len_r);

`ifdef PROG_LOADER_CHKSUM_EN
  logic chk_clear;
  logic chk_add;
  logic chk_ok;

  assign chk_clear = (state == ST_IDLE) && accept;
  assign chk_add   = (state == ST_LOAD) && accept;

  prog_loader_chksum #(
    .DATA_W (DATA_W)
  ) u_chksum (
    .clk   (clk),
    .clr   (clr),
    .clear (chk_clear),
    .add   (chk_add),
    .data  (in_data),
    .pass  (chk_ok)
  );
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    sap_clr  = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_nx = len_ok ? ST_LOAD : ST_ERR;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_byte) begin
`ifdef PROG_LOADER_CHKSUM_EN
          state_nx = ST_CHECK;
`else
          state_nx = ST_HOLD;
`endif
        end
      end
`ifdef PROG_LOADER_CHKSUM_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          state_nx = chk_ok ? ST_HOLD : ST_ERR;
        end
      end
`endif
      ST_HOLD: begin
        busy = 1'b1;
        if (hold_cnt == 4'(HOLD_CYCLES - 1)) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        sap_clr = 1'b0;
        done    = 1'b1;
        if (load_req) begin
          state_nx = ST_IDLE;
        end
      end
      ST_ERR: begin
        err = 1'b1;
        if (load_req) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      len_r     <= '0;
      cnt       <= '0;
      hold_cnt  <= 4'd0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      if ((state == ST_IDLE) && accept) begin
        len_r <= LEN_W'(in_data);
        cnt   <= '0;
      end
      // Write address follows accepted bytes only, so stalls leave no holes.
      if ((state == ST_LOAD) && accept) begin
        ram_we    <= 1'b1;
        ram_addr  <= cnt[ADDR_W-1:0];
        ram_wdata <= in_data;
        cnt       <= cnt + LEN_W'(1);
      end
      if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt + 4'd1;
      end else begin
        hold_cnt <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader_sap.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader_sap
// Brief    : Directed scoreboard bench for prog_loader_sap (either macro build).
// Revision : 1.0
// ============================================================================
module tb_prog_loader_sap;

  logic       clk;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       load_req;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       sap_clr;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_e;
  logic [7:0]  sum = 8'h00;
  logic [7:0]  demo [12] = '{8'h09, 8'hE0, 8'h1A, 8'h2B, 8'hE0, 8'hF0,
                             8'h00, 8'h00, 8'h00, 8'h36, 8'h0F, 8'h0E};

  prog_loader_sap #(
    .ADDR_W      (4),
    .DATA_W      (8),
    .HOLD_CYCLES (2)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .sap_clr   (sap_clr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (clr && ram_we) begin
      wr_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%0h_%0h expected=none", ram_addr, ram_wdata);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        assert ({ram_addr, ram_wdata} === exp_e) else begin
          errors++;
          $error("FAIL write observed=%0h_%0h expected=%0h_%0h",
                 ram_addr, ram_wdata, exp_e[11:8], exp_e[7:0]);
        end
      end
    end
  end

  // Presents one byte and returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b, input logic is_data, input logic [3:0] addr);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    if (is_data) begin
      exp_q.push_back({addr, b});
      sum = sum + b;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_len(input logic [7:0] l);
    sum = 8'h00;
    send(l, 1'b0, 4'd0);
  endtask

  task automatic end_image();
`ifdef PROG_LOADER_CHKSUM_EN
    send(8'h00 - sum, 1'b0, 4'd0);
`endif
  endtask

  task automatic wait_run(input string tag);
    chk({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_hold_done"}, {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_hold2_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold2_clr"}, {31'd0, sap_clr}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_run_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_run_clr"}, {31'd0, sap_clr}, 32'd0);
    chk({tag, "_run_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic pulse_load_req(input string tag);
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idle_clr"}, {31'd0, sap_clr}, 32'd1);
    chk({tag, "_idle_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int w0;
    logic [7:0] bad_len [2];
    bad_len[0] = 8'h00;
    bad_len[1] = 8'h11;
    clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; load_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sap_clr", {31'd0, sap_clr}, 32'd1);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_ram", {19'd0, ram_we, ram_addr, ram_wdata}, 32'd0);
    @(negedge clk) clr = 1'b1;

    // Demo image
    w0 = wr_cnt;
    send_len(8'h0C);
    for (int i = 0; i < 12; i++) send(demo[i], 1'b1, 4'(i));
    end_image();
    wait_run("demo");
    chk("demo_writes", 32'(wr_cnt - w0), 32'd12);

    // Asynchronous reset from RUN, mid-cycle
    @(posedge clk); #2;
    clr = 1'b0;
    #1;
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_sap_clr", {31'd0, sap_clr}, 32'd1);
    chk("arst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("arst_ram", {19'd0, ram_we, ram_addr, ram_wdata}, 32'd0);
    @(negedge clk) clr = 1'b1;

    // Illegal lengths
    for (int k = 0; k < 2; k++) begin
      w0 = wr_cnt;
      send_len(bad_len[k]);
      chk("badlen_err", {31'd0, err}, 32'd1);
      chk("badlen_sap_clr", {31'd0, sap_clr}, 32'd1);
      chk("badlen_ready", {31'd0, in_ready}, 32'd0);
      chk("badlen_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("badlen_writes", 32'(wr_cnt - w0), 32'd0);
      pulse_load_req("badlen");
    end

    // Backpressure
    w0 = wr_cnt;
    send_len(8'h03);
    send(8'hAA, 1'b1, 4'd0);
    repeat (2) @(posedge clk);
    send(8'hBB, 1'b1, 4'd1);
    repeat (2) @(posedge clk);
    send(8'hCC, 1'b1, 4'd2);
    end_image();
    wait_run("bp");
    chk("bp_writes", 32'(wr_cnt - w0), 32'd3);
    pulse_load_req("bp");

    // Full-capacity image: address must not wrap before the last write
    w0 = wr_cnt;
    send_len(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i * 7 + 3), 1'b1, 4'(i));
    end_image();
    wait_run("full");
    chk("full_writes", 32'(wr_cnt - w0), 32'd16);
    pulse_load_req("full");

    // Reset after 3 of 5 data bytes; the third write strobe is dropped
    send_len(8'h05);
    send(8'h11, 1'b1, 4'd0);
    send(8'h22, 1'b1, 4'd1);
    send(8'h33, 1'b0, 4'd2);
    chk("midrst_pending_we", {31'd0, ram_we}, 32'd1);
    #1;
    clr = 1'b0;
    #1;
    chk("midrst_we", {31'd0, ram_we}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) clr = 1'b1;
    send_len(8'h01);
    send(8'h55, 1'b1, 4'd0);
    end_image();
    wait_run("fresh");
    pulse_load_req("fresh");

`ifdef PROG_LOADER_CHKSUM_EN
    send_len(8'h02);
    send(8'h01, 1'b1, 4'd0);
    send(8'h02, 1'b1, 4'd1);
    send(8'hFD, 1'b0, 4'd0);
    wait_run("ck_good");
    pulse_load_req("ck_good");
    send_len(8'h02);
    send(8'h01, 1'b1, 4'd0);
    send(8'h02, 1'b1, 4'd1);
    send(8'hFE, 1'b0, 4'd0);
    chk("ck_bad_err", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    chk("ck_bad_sap_clr", {31'd0, sap_clr}, 32'd1);
    chk("ck_bad_done", {31'd0, done}, 32'd0);
    pulse_load_req("ck_bad");
`endif

    repeat (2) @(posedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
